chip_link_arbiter: RTL



---
 rtl/chip_link_pkg.sv | 15 +
 rtl/chip_link_arbiter_rr_pick.sv | 30 +++
 rtl/chip_link_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/chip_link_pkg.sv
// Shared definitions for the inter-chip link arbiters: flit width, NoC header
// payload-length field position, and the packet-tracking FSM states.
package chip_link_pkg;
   localparam int FLIT_W     = 64;
   localparam int MSG_LEN_LO = 22;
   localparam int MSG_LEN_HI = 29;
   localparam int MSG_LEN_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   typedef logic [MSG_LEN_W-1:0] msg_len_t;
endpackage

// File: rtl/chip_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping at N.
// idx falls back to ptr when nothing is requesting.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx
);
   int           j;
   logic [N-1:0] rot;

   always_comb begin
      any = 1'b0;
      idx = ptr;
      j   = 0;
      rot = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         rot = req >> j;
         if (!any && rot[0]) begin
            any = 1'b1;
            idx = W'(j);
         end
      end
   end
endmodule

// File: rtl/chip_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one inter-chip link among NUM_SRC flit sources.
// Zero-cycle data path, grant held header-to-tail; in_rdy follows out_rdy combinationally.
module chip_link_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 2,
   parameter int FLIT_W  = chip_link_pkg::FLIT_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        in_val,
   input  logic [NUM_SRC*FLIT_W-1:0] in_dat,
   output logic [NUM_SRC-1:0]        in_rdy,
   output logic                      out_val,
   output logic [FLIT_W-1:0]         out_dat,
   input  logic                      out_rdy,
   output logic [SRC_W-1:0]          out_src,
   output logic                      pkt_done,
   output logic                      busy
);
   import chip_link_pkg::*;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   grant_q, grant_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   msg_len_t           remaining_q, remaining_d;
   logic               pkt_done_q, pkt_done_d;
   logic               pick_any;
   logic [SRC_W-1:0]   pick_idx;
   logic [SRC_W-1:0]   sel;
   logic [NUM_SRC-1:0] sel_mask;
   logic [FLIT_W-1:0]  sel_dat;
   msg_len_t           hdr_len;
   logic               out_go;

   // Explicit wrap so non-power-of-2 source counts never point at an unused index.
   function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
      if (int'(s) >= NUM_SRC - 1) return '0;
      return s + 1'b1;
   endfunction

   rr_pick #(
      .N(NUM_SRC),
      .W(SRC_W)
   ) u_pick (
      .req(in_val),
      .ptr(rr_ptr_q),
      .any(pick_any),
      .idx(pick_idx)
   );

   always_comb begin
      sel      = (state_q == BODY) ? grant_q : pick_idx;
      sel_mask = NUM_SRC'(1) << sel;
      sel_dat  = FLIT_W'(in_dat >> (int'(sel) * FLIT_W));
      // In IDLE with no request sel is rr_ptr, whose in_val is low, so this covers both states.
      out_val  = rst_n & (|(in_val & sel_mask));
      out_dat  = out_val ? sel_dat : '0;
      out_src  = sel;
      in_rdy   = (rst_n && out_rdy && (state_q == BODY || pick_any)) ? sel_mask : '0;
      hdr_len  = sel_dat[MSG_LEN_HI:MSG_LEN_LO];
      out_go   = out_val & out_rdy;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      remaining_d = remaining_q;
      pkt_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (out_go) begin
               if (hdr_len == '0) begin
                  rr_ptr_d   = next_src(sel);
                  pkt_done_d = 1'b1;
               end else begin
                  state_d     = BODY;
                  grant_d     = sel;
                  remaining_d = hdr_len;
               end
            end
         end
         BODY: begin
            if (out_go) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == msg_len_t'(1)) begin
                  state_d    = IDLE;
                  rr_ptr_d   = next_src(grant_q);
                  pkt_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         remaining_q <= '0;
         pkt_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         remaining_q <= remaining_d;
         pkt_done_q  <= pkt_done_d;
      end
   end

   assign pkt_done = pkt_done_q;
   assign busy     = (state_q == BODY);
endmodule
